// File: rtl/sdram_wr_pkg.sv
// Shared definitions for the SDRAM write-side drain controller and its helpers.
package sdram_wr_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        BURST = 2'd2,
        ADV   = 2'd3
    } state_t;

    localparam int DEF_ADDR_WIDTH = 24;
    localparam int DEF_NUM_WIDTH  = 10;

endpackage

// File: rtl/sdram_addr_wrap.sv
// Next burst start address inside [ADDR_MIN, ADDR_MAX]; wraps when the following
// burst of the same length would run past ADDR_MAX.
module sdram_addr_wrap
    import sdram_wr_pkg::*;
#(
    parameter int                    ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int                    NUM_WIDTH  = DEF_NUM_WIDTH,
    parameter logic [ADDR_WIDTH-1:0] ADDR_MIN   = '0,
    parameter logic [ADDR_WIDTH-1:0] ADDR_MAX   = '1
) (
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [NUM_WIDTH-1:0]  len,
    output logic [ADDR_WIDTH-1:0] next_addr
);

    localparam int AW1 = ADDR_WIDTH + 1;

    logic [AW1-1:0] next_ext;
    logic [AW1-1:0] last_ext;

    // One extra bit so a region ending at the top of the address space cannot alias.
    always_comb begin
        next_ext = {1'b0, addr} + AW1'(len);
        last_ext = next_ext + AW1'(len) - AW1'(1);
        if (last_ext > {1'b0, ADDR_MAX})
            next_addr = ADDR_MIN;
        else
            next_addr = next_ext[ADDR_WIDTH-1:0];
    end

endmodule

// File: rtl/sdram_wr_burst_ctrl.sv
// Drains the write FIFO into SDRAM bursts: request, stream beats, advance address.
// Optional partial-burst flush is enabled by defining SDRAM_WR_FLUSH_EN.
module sdram_wr_burst_ctrl
    import sdram_wr_pkg::*;
#(
    parameter int                    DATA_WIDTH    = 16,
    parameter int                    NUM_WIDTH     = DEF_NUM_WIDTH,
    parameter int                    ADDR_WIDTH    = DEF_ADDR_WIDTH,
    parameter int                    BURST_LEN     = 256,
`ifdef SDRAM_WR_FLUSH_EN
    parameter int                    FLUSH_TIMEOUT = 1024,
`endif
    parameter logic [ADDR_WIDTH-1:0] ADDR_MIN      = '0,
    parameter logic [ADDR_WIDTH-1:0] ADDR_MAX      = '1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
`ifdef SDRAM_WR_FLUSH_EN
    input  logic                  flush,
`endif
    input  logic [NUM_WIDTH-1:0]  fifo_use_num,
    output logic                  fifo_rd_req,
    input  logic [DATA_WIDTH-1:0] fifo_rd_data,
    output logic                  wr_burst_req,
    output logic [ADDR_WIDTH-1:0] wr_burst_addr,
    output logic [NUM_WIDTH-1:0]  wr_burst_len,
    input  logic                  wr_grant,
    input  logic                  wr_data_req,
    output logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  wr_done,
    output logic                  busy,
    output logic                  overrun
);

    state_t                state;
    logic [NUM_WIDTH-1:0]  beat_cnt;
    logic                  beat_avail;
    logic                  full_ready;
    logic [ADDR_WIDTH-1:0] next_addr;

    assign beat_avail  = beat_cnt < wr_burst_len;
    assign full_ready  = fifo_use_num >= NUM_WIDTH'(BURST_LEN);
    assign fifo_rd_req = (state == BURST) && wr_data_req && beat_avail;
    assign wr_data     = fifo_rd_data;
    assign busy        = (state != IDLE);

    sdram_addr_wrap #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .NUM_WIDTH  (NUM_WIDTH),
        .ADDR_MIN   (ADDR_MIN),
        .ADDR_MAX   (ADDR_MAX)
    ) u_addr_wrap (
        .addr      (wr_burst_addr),
        .len       (wr_burst_len),
        .next_addr (next_addr)
    );

`ifdef SDRAM_WR_FLUSH_EN
    localparam int TW = $clog2(FLUSH_TIMEOUT + 1);

    logic [TW-1:0] idle_cnt;
    logic          flush_seen;
    logic          partial_go;

    assign partial_go = (fifo_use_num != '0) &&
                        (flush || flush_seen || (idle_cnt >= TW'(FLUSH_TIMEOUT)));

    // Idle-with-data timer saturates at the timeout; a flush pulse is remembered until used.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idle_cnt   <= '0;
            flush_seen <= 1'b0;
        end else if (state != IDLE || fifo_use_num == '0) begin
            idle_cnt   <= '0;
            flush_seen <= 1'b0;
        end else begin
            if (idle_cnt < TW'(FLUSH_TIMEOUT))
                idle_cnt <= idle_cnt + TW'(1);
            if (flush)
                flush_seen <= 1'b1;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            wr_burst_req  <= 1'b0;
            wr_burst_addr <= ADDR_MIN;
            wr_burst_len  <= NUM_WIDTH'(BURST_LEN);
            beat_cnt      <= '0;
            overrun       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (enable && full_ready) begin
                        state        <= REQ;
                        wr_burst_req <= 1'b1;
                        wr_burst_len <= NUM_WIDTH'(BURST_LEN);
                    end
`ifdef SDRAM_WR_FLUSH_EN
                    else if (enable && partial_go) begin
                        state        <= REQ;
                        wr_burst_req <= 1'b1;
                        wr_burst_len <= fifo_use_num;
                    end
`endif
                end
                // Request is never retracted once raised, even if enable drops.
                REQ: begin
                    if (wr_grant) begin
                        state        <= BURST;
                        wr_burst_req <= 1'b0;
                    end
                end
                BURST: begin
                    if (fifo_rd_req)
                        beat_cnt <= beat_cnt + NUM_WIDTH'(1);
                    if ((wr_data_req && !beat_avail) || (wr_done && beat_avail))
                        overrun <= 1'b1;
                    if (wr_done)
                        state <= ADV;
                end
                ADV: begin
                    wr_burst_addr <= next_addr;
                    beat_cnt      <= '0;
                    state         <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sdram_wr_burst_ctrl.sv
// Directed bench for sdram_wr_burst_ctrl with a 1 KiW write region (ADDR_MAX = 0x3FF).
module tb_sdram_wr_burst_ctrl;

    localparam int DW = 16;
    localparam int NW = 10;
    localparam int AW = 24;

    logic          clk;
    logic          rst_n;
    logic          enable;
    logic          flush;
    logic [NW-1:0] fifo_use_num;
    logic          fifo_rd_req;
    logic [DW-1:0] fifo_rd_data;
    logic          wr_burst_req;
    logic [AW-1:0] wr_burst_addr;
    logic [NW-1:0] wr_burst_len;
    logic          wr_grant;
    logic          wr_data_req;
    logic [DW-1:0] wr_data;
    logic          wr_done;
    logic          busy;
    logic          overrun;

    int n_checks;
    int n_fail;

    sdram_wr_burst_ctrl #(
        .DATA_WIDTH (DW),
        .NUM_WIDTH  (NW),
        .ADDR_WIDTH (AW),
        .BURST_LEN  (256),
        .ADDR_MIN   (24'h000000),
        .ADDR_MAX   (24'h0003FF)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .enable        (enable),
`ifdef SDRAM_WR_FLUSH_EN
        .flush         (flush),
`endif
        .fifo_use_num  (fifo_use_num),
        .fifo_rd_req   (fifo_rd_req),
        .fifo_rd_data  (fifo_rd_data),
        .wr_burst_req  (wr_burst_req),
        .wr_burst_addr (wr_burst_addr),
        .wr_burst_len  (wr_burst_len),
        .wr_grant      (wr_grant),
        .wr_data_req   (wr_data_req),
        .wr_data       (wr_data),
        .wr_done       (wr_done),
        .busy          (busy),
        .overrun       (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Waits for the request, grants it, streams nbeats data requests and completes the burst.
    task automatic run_burst(input string tag, input int nbeats, input int exp_len,
                             input logic [AW-1:0] exp_addr, input logic [AW-1:0] exp_next);
        bit   got;
        logic pop;
        got = 0;
        for (int w = 0; w < 2 && !got; w++) begin
            @(negedge clk);
            if (wr_burst_req === 1'b1) got = 1;
        end
        n_checks++;
        if (!got) begin
            n_fail++;
            $display("FAIL %s_req_rise: wr_burst_req=%b, required 1 within 2 cycles", tag, wr_burst_req);
        end
        n_checks++;
        if (wr_burst_addr !== exp_addr) begin
            n_fail++;
            $display("FAIL %s_addr: got %h, required %h", tag, wr_burst_addr, exp_addr);
        end
        n_checks++;
        if (wr_burst_len !== NW'(exp_len)) begin
            n_fail++;
            $display("FAIL %s_len: got %0d, required %0d", tag, wr_burst_len, exp_len);
        end
        wr_grant = 1'b1;
        @(negedge clk);
        wr_grant = 1'b0;
        n_checks++;
        if (wr_burst_req !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_grant: req=%b busy=%b, required req=0 busy=1", tag, wr_burst_req, busy);
        end
        for (int i = 0; i < nbeats; i++) begin
            wr_data_req = 1'b1;
            #1;
            n_checks++;
            if (fifo_rd_req !== (i < exp_len)) begin
                n_fail++;
                $display("FAIL %s_pop beat %0d: fifo_rd_req=%b, required %b", tag, i, fifo_rd_req, (i < exp_len));
            end
            pop = fifo_rd_req;
            @(posedge clk);
            #1;
            if (pop === 1'b1) begin
                fifo_rd_data = DW'(i + 1);
                fifo_use_num = fifo_use_num - 1'b1;
            end
            @(negedge clk);
            if (pop === 1'b1) begin
                n_checks++;
                if (wr_data !== DW'(i + 1)) begin
                    n_fail++;
                    $display("FAIL %s_data beat %0d: got %0d, required %0d", tag, i, wr_data, i + 1);
                end
            end
        end
        wr_data_req = 1'b0;
        wr_done = 1'b1;
        @(negedge clk);
        wr_done = 1'b0;
        @(negedge clk);
        n_checks++;
        if (wr_burst_addr !== exp_next || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_next_addr: addr=%h busy=%b, required addr=%h busy=0", tag, wr_burst_addr, busy, exp_next);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if (wr_burst_req !== 1'b0 || fifo_rd_req !== 1'b0 || busy !== 1'b0 || overrun !== 1'b0 ||
            wr_burst_addr !== 24'h0 || wr_burst_len !== 10'd256) begin
            n_fail++;
            $display("FAIL reset_state: req=%b rd=%b busy=%b ovr=%b addr=%h len=%0d, required 0 0 0 0 000000 256",
                     wr_burst_req, fifo_rd_req, busy, overrun, wr_burst_addr, wr_burst_len);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_burst();
        bit bad;
        fifo_use_num = 10'd256;
        enable = 1'b0;
        bad = 0;
        repeat (5) begin
            @(negedge clk);
            if (wr_burst_req !== 1'b0 || busy !== 1'b0) bad = 1;
        end
        n_checks++;
        if (bad) begin
            n_fail++;
            $display("FAIL enable_gate: request raised with enable=0, required none");
        end
        enable = 1'b1;
        run_burst("burst0", 256, 256, 24'h000000, 24'h000100);
        n_checks++;
        if (overrun !== 1'b0) begin
            n_fail++;
            $display("FAIL burst0_overrun: got %b, required 0", overrun);
        end
    endtask

    task automatic test_threshold();
        bit bad;
        fifo_use_num = 10'd255;
        bad = 0;
        repeat (100) begin
            @(negedge clk);
            if (wr_burst_req !== 1'b0) bad = 1;
        end
        n_checks++;
        if (bad) begin
            n_fail++;
            $display("FAIL threshold_255: request raised with 255 words, required none");
        end
        fifo_use_num = 10'd256;
        run_burst("thresh", 256, 256, 24'h000100, 24'h000200);
    endtask

    task automatic test_wrap();
        fifo_use_num = 10'd256;
        run_burst("wrap2", 256, 256, 24'h000200, 24'h000300);
        fifo_use_num = 10'd256;
        run_burst("wrap3", 256, 256, 24'h000300, 24'h000000);
    endtask

    task automatic test_overrun();
        fifo_use_num = 10'd256;
        run_burst("ovr", 257, 256, 24'h000000, 24'h000100);
        n_checks++;
        if (overrun !== 1'b1) begin
            n_fail++;
            $display("FAIL overrun_set: got %b, required 1", overrun);
        end
        repeat (10) @(negedge clk);
        n_checks++;
        if (overrun !== 1'b1) begin
            n_fail++;
            $display("FAIL overrun_sticky: got %b, required 1", overrun);
        end
    endtask

    task automatic test_reset_mid_burst();
        bit got;
        fifo_use_num = 10'd256;
        got = 0;
        for (int w = 0; w < 2 && !got; w++) begin
            @(negedge clk);
            if (wr_burst_req === 1'b1) got = 1;
        end
        n_checks++;
        if (!got || wr_burst_addr !== 24'h000100) begin
            n_fail++;
            $display("FAIL abort_req: req=%b addr=%h, required 1 000100", wr_burst_req, wr_burst_addr);
        end
        wr_grant = 1'b1;
        @(negedge clk);
        wr_grant = 1'b0;
        wr_data_req = 1'b1;
        repeat (100) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (wr_burst_req !== 1'b0 || fifo_rd_req !== 1'b0 || busy !== 1'b0 || overrun !== 1'b0 ||
            wr_burst_addr !== 24'h0 || wr_burst_len !== 10'd256) begin
            n_fail++;
            $display("FAIL async_abort: req=%b rd=%b busy=%b ovr=%b addr=%h len=%0d, required 0 0 0 0 000000 256",
                     wr_burst_req, fifo_rd_req, busy, overrun, wr_burst_addr, wr_burst_len);
        end
        wr_data_req = 1'b0;
        fifo_use_num = '0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

`ifdef SDRAM_WR_FLUSH_EN
    task automatic test_flush();
        fifo_use_num = 10'd10;
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        run_burst("flush", 10, 10, 24'h000000, 24'h00000A);
    endtask
`endif

    initial begin
        n_checks     = 0;
        n_fail       = 0;
        rst_n        = 1'b0;
        enable       = 1'b0;
        flush        = 1'b0;
        fifo_use_num = '0;
        fifo_rd_data = '0;
        wr_grant     = 1'b0;
        wr_data_req  = 1'b0;
        wr_done      = 1'b0;
        test_reset();
        test_burst();
        test_threshold();
        test_wrap();
        test_overrun();
        test_reset_mid_burst();
`ifdef SDRAM_WR_FLUSH_EN
        test_flush();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
